// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: instruction field positions, halt opcode and the OF/EX payload.
// The OF/EX payload is sized by XLEN_DEF; the operand-fetch stage is built for that width.
package simplerisc_pkg;

  localparam int XLEN_DEF = 32;

  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int IMM_W   = 16;
  localparam int BOFF_W  = 27;

  localparam logic [4:0] HALT_OPCODE = 5'b11111;

  typedef struct packed {
    logic [XLEN_DEF-1:0] op1;
    logic [XLEN_DEF-1:0] op2;
    logic [XLEN_DEF-1:0] b;
    logic [XLEN_DEF-1:0] immx;
    logic [XLEN_DEF-1:0] branch_target;
    logic [XLEN_DEF-1:0] pc;
    logic [4:0]          rd;
    logic [OPC_W-1:0]    opcode;
    logic                writes_rd;
  } of_ex_t;

  function automatic logic is_halt(input logic [31:0] inst);
    return inst[31:27] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/of_stage_sb_if.sv
// Decode, writeback and execute-side signals of the operand-fetch stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface of_stage_sb_if
  import simplerisc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            in_is_st;
  logic            in_is_ret;
  logic            in_is_imm;
  logic            in_uses_rs1;
  logic            in_uses_rs2;
  logic            in_writes_rd;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_immx;
  logic [XLEN-1:0] out_branch_target;
  logic [4:0]      out_rd;
  logic [5:0]      out_opcode;
  logic            out_writes_rd;
  logic [XLEN-1:0] out_pc;
  logic            halted;

  modport slave (
    input  in_valid, in_inst, in_pc, in_is_st, in_is_ret, in_is_imm,
    input  in_uses_rs1, in_uses_rs2, in_writes_rd, flush,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_b, out_immx,
    output out_branch_target, out_rd, out_opcode, out_writes_rd, out_pc, halted
  );

  modport master (
    output in_valid, in_inst, in_pc, in_is_st, in_is_ret, in_is_imm,
    output in_uses_rs1, in_uses_rs2, in_writes_rd, flush,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_b, out_immx,
    input  out_branch_target, out_rd, out_opcode, out_writes_rd, out_pc, halted
  );
endinterface

// File: rtl/regfile_sb.sv
// Register array with one pending (in-flight write) bit per register; two reads, one write.
// OF_BYPASS_EN forwards the write port onto both read ports in the same cycle.
module regfile_sb #(
  parameter int  XLEN  = 32,
  parameter int  NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra1_i,
  input  logic [AW-1:0]    ra2_i,
  output logic [XLEN-1:0]  rd1_o,
  output logic [XLEN-1:0]  rd2_o,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [XLEN-1:0]  wd_i,
  input  logic             set_i,
  input  logic [AW-1:0]    set_idx_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_idx_i,
  output logic [NREGS-1:0] pend_o
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Set is applied last so a same-cycle set and clear on one index leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (we_i)  pend_d[wa_i]      = 1'b0;
    if (clr_i) pend_d[clr_idx_i] = 1'b0;
    if (set_i) pend_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend_o = pend_q;

`ifdef OF_BYPASS_EN
  assign rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : mem_q[ra1_i];
  assign rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : mem_q[ra2_i];
`else
  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];
`endif

endmodule

// File: rtl/of_stage_sb.sv
// Operand-fetch stage: register file + scoreboard, RAW/WAW stall, OF/EX register, sticky halt.
// OF_BYPASS_EN forwards same-cycle writeback into the operands and lifts the matching RAW stall.
module of_stage_sb
  import simplerisc_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = 16,
  parameter int RA_REG = NREGS - 1
) (
  input logic          clk,
  input logic          rst_n,
  of_stage_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);
`ifdef OF_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [AW-1:0]    rs1_idx, rs2_idx, rd_idx, wb_idx, flush_idx;
  logic [XLEN-1:0]  rs1_dat, rs2_dat;
  logic [NREGS-1:0] pend;
  logic             fwd1, fwd2, hz, in_rdy, accept, flush_clr;
  of_ex_t           ofex_q, ofex_d, payload;
  logic             out_vld_q, out_vld_d, halted_q, halted_d;

  assign rs1_idx = bus.in_is_ret ? AW'(RA_REG) : bus.in_inst[RS1_LSB +: AW];
  assign rs2_idx = bus.in_is_st ? bus.in_inst[RD_LSB +: AW] : bus.in_inst[RS2_LSB +: AW];
  assign rd_idx  = bus.in_inst[RD_LSB +: AW];
  assign wb_idx  = bus.wb_addr[AW-1:0];

  generate
    if (AW < 5) begin : g_wb_hi
      logic unused_wb_hi;
      assign unused_wb_hi = ^bus.wb_addr[4:AW];
    end
  endgenerate

  // Forwarding only relieves RAW; a pending rd always stalls so writebacks stay ordered.
  assign fwd1 = BYPASS && bus.wb_en && (wb_idx == rs1_idx);
  assign fwd2 = BYPASS && bus.wb_en && (wb_idx == rs2_idx);
  assign hz   = (bus.in_uses_rs1 && pend[rs1_idx] && !fwd1)
             || (bus.in_uses_rs2 && pend[rs2_idx] && !fwd2)
             || (bus.in_writes_rd && pend[rd_idx]);

  assign in_rdy    = !halted_q && !hz && (!out_vld_q || bus.out_ready) && !bus.flush;
  assign accept    = bus.in_valid && in_rdy;
  assign flush_clr = bus.flush && out_vld_q && ofex_q.writes_rd;
  assign flush_idx = ofex_q.rd[AW-1:0];

  regfile_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra1_i     (rs1_idx),
    .ra2_i     (rs2_idx),
    .rd1_o     (rs1_dat),
    .rd2_o     (rs2_dat),
    .we_i      (bus.wb_en),
    .wa_i      (wb_idx),
    .wd_i      (bus.wb_data),
    .set_i     (accept && bus.in_writes_rd),
    .set_idx_i (rd_idx),
    .clr_i     (flush_clr),
    .clr_idx_i (flush_idx),
    .pend_o    (pend)
  );

  always_comb begin
    payload               = '0;
    payload.op1           = rs1_dat;
    payload.op2           = rs2_dat;
    payload.immx          = {{(XLEN-IMM_W){bus.in_inst[IMM_W-1]}}, bus.in_inst[IMM_W-1:0]};
    payload.b             = bus.in_is_imm ? payload.immx : rs2_dat;
    payload.branch_target = bus.in_pc
                          + {{(XLEN-BOFF_W){bus.in_inst[BOFF_W-1]}}, bus.in_inst[BOFF_W-1:0]};
    payload.pc            = bus.in_pc;
    payload.rd            = bus.in_inst[RD_LSB +: 5];
    payload.opcode        = bus.in_inst[OPC_LSB +: OPC_W];
    payload.writes_rd     = bus.in_writes_rd;
  end

  // Flush and accept are exclusive (in_ready is low during flush), so a halt never latches then.
  always_comb begin
    ofex_d    = ofex_q;
    out_vld_d = out_vld_q;
    halted_d  = halted_q;
    if (accept) begin
      ofex_d    = payload;
      out_vld_d = 1'b1;
      halted_d  = halted_q | is_halt(bus.in_inst);
    end else if (bus.flush || bus.out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ofex_q    <= '0;
      out_vld_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      ofex_q    <= ofex_d;
      out_vld_q <= out_vld_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.in_ready          = in_rdy;
  assign bus.out_valid         = out_vld_q;
  assign bus.out_op1           = ofex_q.op1;
  assign bus.out_op2           = ofex_q.op2;
  assign bus.out_b             = ofex_q.b;
  assign bus.out_immx          = ofex_q.immx;
  assign bus.out_branch_target = ofex_q.branch_target;
  assign bus.out_rd            = ofex_q.rd;
  assign bus.out_opcode        = ofex_q.opcode;
  assign bus.out_writes_rd     = ofex_q.writes_rd;
  assign bus.out_pc            = ofex_q.pc;
  assign bus.halted            = halted_q;

endmodule

// File: tb/tb_of_stage_sb.sv
// Bench for of_stage_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_of_stage_sb;
  localparam int NR = 16;
  localparam int RA = 15;
`ifdef OF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  of_stage_sb_if #(.XLEN(32)) bus();
  of_stage_sb #(.XLEN(32), .NREGS(NR), .RA_REG(RA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference state: architectural registers, in-flight writes, OF/EX contents.
  logic [31:0] m_regs [NR];
  bit          m_pend [NR];
  bit          m_ov, m_halt, m_wr;
  logic [31:0] m_op1, m_op2, m_b, m_immx, m_bt, m_pc;
  logic [4:0]  m_rd;
  logic [5:0]  m_opc;

  function automatic int idx(input logic [4:0] f);
    return int'(f) % NR;
  endfunction
  function automatic int src1();
    return bus.in_is_ret ? RA : idx(bus.in_inst[20:16]);
  endfunction
  function automatic int src2();
    return bus.in_is_st ? idx(bus.in_inst[25:21]) : idx(bus.in_inst[15:11]);
  endfunction
  function automatic bit fwd(input int r);
    return BYP && bus.wb_en && (idx(bus.wb_addr) == r);
  endfunction
  function automatic bit m_ready();
    bit raw1, raw2, waw;
    raw1 = bus.in_uses_rs1 && m_pend[src1()] && !fwd(src1());
    raw2 = bus.in_uses_rs2 && m_pend[src2()] && !fwd(src2());
    waw  = bus.in_writes_rd && m_pend[idx(bus.in_inst[25:21])];
    return !m_halt && !(raw1 || raw2 || waw) && (!m_ov || bus.out_ready) && !bus.flush;
  endfunction
  function automatic logic [31:0] m_read(input int r);
    return fwd(r) ? bus.wb_data : m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_ov = 0; m_halt = 0; m_wr = 0;
    m_op1 = '0; m_op2 = '0; m_b = '0; m_immx = '0; m_bt = '0; m_pc = '0; m_rd = '0; m_opc = '0;
  endtask

  // One clock: model advances using the inputs held across the edge; returns at the negedge.
  task automatic tick();
    bit acc, nov;
    logic [31:0] w;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = bus.in_valid && m_ready();
      w   = bus.in_inst;
      nov = acc ? 1'b1 : (bus.flush ? 1'b0 : ((m_ov && bus.out_ready) ? 1'b0 : m_ov));
      if (bus.wb_en) m_pend[idx(bus.wb_addr)] = 1'b0;
      if (bus.flush && m_ov && m_wr) m_pend[idx(m_rd)] = 1'b0;
      if (acc) begin
        m_op1  = m_read(src1());
        m_op2  = m_read(src2());
        m_immx = 32'($signed(w[15:0]));
        m_b    = bus.in_is_imm ? m_immx : m_op2;
        m_bt   = bus.in_pc + 32'($signed(w[26:0]));
        m_rd   = w[25:21];
        m_opc  = w[31:26];
        m_wr   = bus.in_writes_rd;
        m_pc   = bus.in_pc;
        if (bus.in_writes_rd) m_pend[idx(w[25:21])] = 1'b1;
        if (w[31:27] == 5'b11111) m_halt = 1'b1;
      end
      if (bus.wb_en) m_regs[idx(bus.wb_addr)] = bus.wb_data;
      m_ov = nov;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] a,
                                     input logic [4:0] b, input logic [15:0] lo);
    return {opc, a, b, lo};
  endfunction

  task automatic idle();
    bus.in_valid = 0; bus.in_inst = '0; bus.in_pc = '0;
    bus.in_is_st = 0; bus.in_is_ret = 0; bus.in_is_imm = 0;
    bus.in_uses_rs1 = 0; bus.in_uses_rs2 = 0; bus.in_writes_rd = 0;
    bus.flush = 0; bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1;
  endtask

  task automatic set_in(input logic [31:0] inst, input bit u1 = 0, input bit u2 = 0,
                        input bit wr = 0, input bit imm = 0, input logic [31:0] pc = 32'h100);
    bus.in_valid = 1; bus.in_inst = inst; bus.in_pc = pc;
    bus.in_is_st = 0; bus.in_is_ret = 0; bus.in_is_imm = imm;
    bus.in_uses_rs1 = u1; bus.in_uses_rs2 = u2; bus.in_writes_rd = wr;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid act=%b exp=0", bus.out_valid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted act=%b exp=0", bus.halted); end
    checks++; if ({bus.out_op1, bus.out_branch_target, bus.out_pc} !== 96'd0) begin errors++; $display("FAIL reset_data act=%h/%h/%h exp=0", bus.out_op1, bus.out_branch_target, bus.out_pc); end
    set_in(mk(6'd1, 5'd3, 5'd1, {5'd2, 11'd0}), 1, 1, 1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready act=%b exp=1", bus.in_ready); end
    idle();
  endtask

  task automatic test_raw();
    int n;
    apply_reset();
    bus.wb_en = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'd5; tick();
    bus.wb_addr = 5'd2; bus.wb_data = 32'd7; tick();
    bus.wb_en = 0;
    set_in(mk(6'd1, 5'd3, 5'd1, {5'd2, 11'd0}), 1, 1, 1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_add_ready act=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.out_valid, bus.out_op1, bus.out_op2} !== {1'b1, 32'd5, 32'd7}) begin errors++; $display("FAIL raw_add_ops act=%b/%0d/%0d exp=1/5/7", bus.out_valid, bus.out_op1, bus.out_op2); end
    set_in(mk(6'd2, 5'd4, 5'd3, {5'd1, 11'd0}), 1, 1, 1);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cyc=%0d act=%b exp=0", k, bus.in_ready); end
      tick();
    end
    bus.wb_en = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'd42;
    n = 0;
    #1;
    while (!bus.in_ready && n < 4) begin
      tick(); bus.wb_en = 0; n++; #1;
    end
    checks++; if (n !== (BYP ? 0 : 1)) begin errors++; $display("FAIL raw_wb_delay act=%0d exp=%0d", n, BYP ? 0 : 1); end
    tick();
    bus.wb_en = 0;
    checks++; if ({bus.out_valid, bus.out_op1, bus.out_op2} !== {1'b1, 32'd42, 32'd5}) begin errors++; $display("FAIL raw_sub_ops act=%b/%0d/%0d exp=1/42/5", bus.out_valid, bus.out_op1, bus.out_op2); end
    idle();
  endtask

  task automatic test_waw();
    apply_reset();
    set_in(mk(6'd3, 5'd5, 5'd0, 16'd0), 0, 0, 1);
    tick();
    set_in(mk(6'd4, 5'd5, 5'd0, 16'd0), 0, 0, 1);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall act=%b exp=0", bus.in_ready); end
    tick();
    bus.wb_en = 1; bus.wb_addr = 5'd21; bus.wb_data = 32'd9;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL waw_no_bypass act=%b exp=0", bus.in_ready); end
    tick();
    bus.wb_en = 0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL waw_release act=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.out_valid, bus.out_opcode, bus.out_rd} !== {1'b1, 6'd4, 5'd5}) begin errors++; $display("FAIL waw_issue act=%b/%0d/%0d exp=1/4/5", bus.out_valid, bus.out_opcode, bus.out_rd); end
    idle();
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_in(mk(6'd7, 5'd8, 5'd0, 16'h8001), 0, 0, 0, 1, 32'h40);
    tick();
    bus.out_ready = 0;
    set_in(mk(6'd9, 5'd9, 5'd0, 16'h0002), 0, 0, 0, 1, 32'h44);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d act=%b exp=0", k, bus.in_ready); end
      tick();
      checks++; if ({bus.out_valid, bus.out_opcode, bus.out_immx, bus.out_b} !== {1'b1, 6'd7, 32'hFFFF8001, 32'hFFFF8001}) begin errors++; $display("FAIL bp_hold cyc=%0d act=%b/%0d/%h/%h exp=1/7/ffff8001/ffff8001", k, bus.out_valid, bus.out_opcode, bus.out_immx, bus.out_b); end
      checks++; if (bus.out_branch_target !== m_bt) begin errors++; $display("FAIL bp_target cyc=%0d act=%h exp=%h", k, bus.out_branch_target, m_bt); end
    end
    bus.out_ready = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume act=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.out_opcode, bus.out_pc} !== {6'd9, 32'h44}) begin errors++; $display("FAIL bp_next act=%0d/%h exp=9/44", bus.out_opcode, bus.out_pc); end
    idle();
  endtask

  task automatic test_flush();
    apply_reset();
    bus.out_ready = 0;
    set_in(mk(6'd10, 5'd6, 5'd0, 16'd0), 0, 0, 1);
    tick();
    set_in(mk(6'd11, 5'd7, 5'd6, 16'd0), 1, 0, 1);
    bus.flush = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready act=%b exp=0", bus.in_ready); end
    tick();
    bus.flush = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid act=%b exp=0", bus.out_valid); end
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_pend_clr act=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.out_valid, bus.out_opcode} !== {1'b1, 6'd11}) begin errors++; $display("FAIL flush_next act=%b/%0d exp=1/11", bus.out_valid, bus.out_opcode); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] w;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      w = $urandom;
      if (w[31:27] == 5'b11111) w[31] = 1'b0;
      bus.in_valid = ($urandom_range(0, 3) != 0); bus.in_inst = w; bus.in_pc = $urandom;
      bus.in_is_st = 1'($urandom_range(0, 1)); bus.in_is_ret = ($urandom_range(0, 5) == 0);
      bus.in_is_imm = 1'($urandom_range(0, 1)); bus.in_uses_rs1 = 1'($urandom_range(0, 1));
      bus.in_uses_rs2 = 1'($urandom_range(0, 1)); bus.in_writes_rd = 1'($urandom_range(0, 1));
      bus.flush = ($urandom_range(0, 15) == 0); bus.wb_en = ($urandom_range(0, 2) != 0);
      bus.wb_addr = 5'($urandom); bus.wb_data = $urandom; bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d act=%b exp=%b", c, bus.in_ready, m_ready()); end
      tick();
      checks++; if ({bus.out_valid, bus.halted} !== {m_ov, m_halt}) begin errors++; $display("FAIL rnd_valid cyc=%0d act=%b%b exp=%b%b", c, bus.out_valid, bus.halted, m_ov, m_halt); end
      checks++; if ({bus.out_op1, bus.out_op2, bus.out_b} !== {m_op1, m_op2, m_b}) begin errors++; $display("FAIL rnd_ops cyc=%0d act=%h/%h/%h exp=%h/%h/%h", c, bus.out_op1, bus.out_op2, bus.out_b, m_op1, m_op2, m_b); end
      checks++; if ({bus.out_immx, bus.out_branch_target, bus.out_pc} !== {m_immx, m_bt, m_pc}) begin errors++; $display("FAIL rnd_fields cyc=%0d act=%h/%h/%h exp=%h/%h/%h", c, bus.out_immx, bus.out_branch_target, bus.out_pc, m_immx, m_bt, m_pc); end
      checks++; if ({bus.out_rd, bus.out_opcode, bus.out_writes_rd} !== {m_rd, m_opc, m_wr}) begin errors++; $display("FAIL rnd_ctl cyc=%0d act=%0d/%0d/%b exp=%0d/%0d/%b", c, bus.out_rd, bus.out_opcode, bus.out_writes_rd, m_rd, m_opc, m_wr); end
    end
    idle();
  endtask

  task automatic test_halt();
    apply_reset();
    set_in(32'hF8000000);
    bus.flush = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_flush_ready act=%b exp=0", bus.in_ready); end
    tick();
    checks++; if ({bus.halted, bus.out_valid} !== 2'b00) begin errors++; $display("FAIL halt_flush act=%b%b exp=00", bus.halted, bus.out_valid); end
    bus.flush = 0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL halt_accept_ready act=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.halted, bus.out_valid} !== 2'b11) begin errors++; $display("FAIL halt_latched act=%b%b exp=11", bus.halted, bus.out_valid); end
    set_in(mk(6'd1, 5'd2, 5'd0, 16'd0));
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready cyc=%0d act=%b exp=0", k, bus.in_ready); end
      tick();
      checks++; if ({bus.halted, bus.out_valid} !== {1'b1, m_ov}) begin errors++; $display("FAIL halt_drain cyc=%0d act=%b%b exp=1%b", k, bus.halted, bus.out_valid, m_ov); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.wb_en = 1; bus.wb_addr = 5'd2; bus.wb_data = 32'h55; tick();
    bus.wb_en = 0; bus.out_ready = 0;
    set_in(mk(6'd5, 5'd2, 5'd0, 16'd0), 0, 0, 1);
    tick();
    set_in(mk(6'd6, 5'd3, 5'd2, 16'd0), 1, 0, 1);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if ({bus.out_valid, bus.out_opcode, bus.halted} !== 8'd0) begin errors++; $display("FAIL rstmid_state act=%b/%0d/%b exp=0/0/0", bus.out_valid, bus.out_opcode, bus.halted); end
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready act=%b exp=1", bus.in_ready); end
    tick();
    checks++; if ({bus.out_valid, bus.out_op1} !== {1'b1, 32'd0}) begin errors++; $display("FAIL rstmid_regs act=%b/%h exp=1/0", bus.out_valid, bus.out_op1); end
    idle();
  endtask

  initial begin
    model_reset();
    idle();
    test_reset();
    test_raw();
    test_waw();
    test_backpressure();
    test_flush();
    test_random();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/of_stage_sb.md
# of_stage_sb

Parametrised operand-fetch stage for the SimpleRISC pipeline, sitting between decode and execute. Holds the architectural register file and a per-register scoreboard of in-flight writes. Stalls decode on RAW/WAW hazards, registers operands and decoded fields into an OF/EX pipeline register behind a valid/ready handshake, and latches a sticky halt. Replaces the single-cycle, hazard-blind operand-fetch block.

## Interface
- XLEN, 32, datapath width.
- NREGS, 16, register count. Power of two, at most 32. Register indices are the low $clog2(NREGS) bits of each 5-bit field.
- RA_REG, NREGS-1, return-address register read by `ret`.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- in_is_st, in_is_ret, in_is_imm  in  1 each  decode flags.
- in_uses_rs1, in_uses_rs2  in  1 each  the source is actually read.
- in_writes_rd  in  1  the instruction writes rd.
- flush  in  1  squash from execute (taken branch).
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  the OF/EX register holds a valid instruction.
- out_ready  in  1  execute consumes the instruction.
- out_op1, out_op2  out  XLEN each  register operands.
- out_b  out  XLEN  immx if is_imm, else op2.
- out_immx  out  XLEN  inst[15:0] sign-extended.
- out_branch_target  out  XLEN  pc + sign-extended inst[26:0].
- out_rd  out  5  destination field.
- out_opcode  out  6  inst[31:26].
- out_writes_rd, out_pc  out  1/XLEN  forwarded from decode.
- halted  out  1  sticky halt.

## Operation
- Source selection:
  - rs1 = RA_REG if is_ret, else inst[20:16].
  - rs2 = inst[25:21] if is_st, else inst[15:11].
  - rd = inst[25:21].
- Scoreboard: one pending bit per register.
  - Set when an instruction with writes_rd is accepted, at index rd.
  - Cleared by wb_en at wb_addr.
  - If a set and a clear hit the same index in the same cycle, set wins.
- Hazard. Raise hz if any of the following holds:
  - uses_rs1 and rs1 is pending;
  - uses_rs2 and rs2 is pending;
  - writes_rd and rd is pending.
  - With bypass enabled, a pending source whose index equals wb_addr while wb_en is high does not count. The WAW check is never bypassed.
- in_ready = !halted && !hz && (!out_valid || out_ready) && !flush.
- On accept:
  - The OF/EX register loads the operands and fields.
  - out_valid becomes 1.
  - If the instruction is a halt (inst[31:27]==5'b11111), halted becomes 1.
- If out_valid && out_ready and nothing is accepted, out_valid clears.
- Flush:
  - out_valid clears.
  - If the squashed instruction had out_writes_rd, its pending bit for out_rd clears.
  - Nothing is accepted in the flush cycle.
  - A halt is never latched during a flush.
- Register file writes occur on the clock edge when wb_en is high.
- Halted state: in_ready stays 0 until reset. The instruction already in OF/EX still drains.

## Timing
- Latency: accept at edge N, and out_* are valid after edge N.
- Writeback at edge N is visible to a fetch in cycle N+1 without bypass. With bypass it is visible in cycle N itself.
- Reset values:
  - out_valid=0, halted=0, all pending bits 0, all registers 0.
  - out_* data fields are 0.
- A reset asserted mid-stall or mid-drain discards all state.
- Backpressure: when out_ready=0 and out_valid=1, the OF/EX register holds and in_ready=0.
- All outputs except in_ready are registered. in_ready is combinational.

## Configuration
- OF_BYPASS_EN defined:
  - same-cycle writeback data is forwarded into out_op1/out_op2;
  - the RAW stall is suppressed for that register.
- OF_BYPASS_EN undefined:
  - the register file read reflects only completed writes;
  - a RAW on a register written this cycle stalls one extra cycle.

## Structure
- Shared package `simplerisc_pkg`:
  - XLEN default;
  - opcode field positions;
  - HALT_OPCODE (5'b11111);
  - an `of_ex_t` struct for the OF/EX payload.
- One sub-module, `regfile_sb`, holds the register array, the pending bits, and the optional bypass. It has two read ports, one write port, and set/clear ports for the scoreboard.

## Test plan
- Reset, then issue `add r3,r1,r2` with r1=5 and r2=7 preloaded via writeback → one cycle later out_op1=5, out_op2=7, and pending[3]=1.
- Back-to-back `add r3,..` then `sub r4,r3,r1`, no writeback → in_ready=0 until wb_en to r3 with 42. Then:
  - with bypass: accepted the same cycle, out_op1=42;
  - without bypass: accepted one cycle later, out_op1=42.
- Instruction writing r5 while r5 is pending → stalls until wb_en to r5, even with bypass.
- out_ready=0 for 3 cycles with out_valid=1 → out_* stable, in_ready=0, then resumes.
- flush while OF/EX holds an instruction writing r6 → out_valid=0 next cycle, pending[6]=0, no accept that cycle.
- Accept a halt word 0xF8000000 → halted=1 and in_ready=0 permanently. The same word presented during flush → halted stays 0.
